// File: rtl/regbank_reader_pkg.sv
// Shared defaults and state encoding for the register-bank read-out engine.
// Keeping the bank geometry here lets the bank and the reader agree on sizes.
package regbank_reader_pkg;

    localparam int unsigned DefNumRegs = 8;
    localparam int unsigned DefAddrW   = 3;
    localparam int unsigned DefDataW   = 8;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StWait = 3'd2,
        StSend = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/regbank_reader_ctr.sv
// Wrapping address counter plus remaining-word count for the read-out engine.
// A load count of zero stands for a full sweep of NUM_REGS registers.
module regbank_reader_ctr
    import regbank_reader_pkg::*;
#(
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned ADDR_W   = DefAddrW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_count,
    input  logic              dec,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last
);

    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);

    logic [ADDR_W:0] remaining;

    // NUM_REGS is a power of two, so the natural overflow of the add is the wrap.
    assign next_addr = cur_addr + AddrOne;
    assign last      = (remaining == CountOne);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_addr  <= load_addr;
            remaining <= (load_count == '0) ? FullCount : load_count;
        end else if (dec) begin
            cur_addr  <= next_addr;
            remaining <= remaining - CountOne;
        end
    end

endmodule

// File: rtl/regbank_reader.sv
// Sequential read-out engine: walks a wrapping address range of the register
// bank and streams each word, tagged with its address, over valid/ready.
module regbank_reader
    import regbank_reader_pkg::*;
#(
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W:0]   count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_last_o
);

    state_e            state;
    logic              load;
    logic              dec;
    logic              handshake;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              last;

    assign handshake = (state == StSend) && out_valid_o && out_ready_i;
    assign load      = (state == StIdle) && start_i;
    assign dec       = handshake;

    regbank_reader_ctr #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_ctr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load       (load),
        .load_addr  (first_addr_i),
        .load_count (count_i),
        .dec        (dec),
        .cur_addr   (cur_addr),
        .next_addr  (next_addr),
        .last       (last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= StIdle;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_addr_o  <= '0;
            out_last_o  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start_i) begin
                        state     <= StReq;
                        busy_o    <= 1'b1;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= first_addr_i;
                    end
                end
                StReq: begin
                    rd_en_o   <= 1'b0;
                    rd_addr_o <= '0;
                    state     <= StWait;
                end
                StWait: begin
                    // Bank data for the strobe issued in REQ is valid this cycle.
                    out_data_o  <= rd_data_i;
                    out_addr_o  <= cur_addr;
                    out_last_o  <= last;
                    out_valid_o <= 1'b1;
                    state       <= StSend;
                end
                StSend: begin
                    if (handshake) begin
                        out_valid_o <= 1'b0;
                        if (out_last_o) begin
                            state  <= StDone;
                            done_o <= 1'b1;
                        end else begin
                            // Counter advances on this same edge; issue the next address now.
                            state     <= StReq;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= next_addr;
                        end
                    end
                end
                StDone: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    state       <= StIdle;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                    rd_en_o     <= 1'b0;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_reader.sv
// Directed self-checking bench for regbank_reader with a behavioural register bank.
module tb_regbank_reader;

    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    logic [DW-1:0] mem [NR];
    int n_checks = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    int hs_cnt = 0;

    regbank_reader #(
        .NUM_REGS (NR),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .first_addr_i (first_addr),
        .count_i      (count),
        .busy_o       (busy),
        .done_o       (done),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_addr_o   (out_addr),
        .out_last_o   (out_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read bank: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(posedge clk) begin
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int fa, input int cnt);
        first_addr = AW'(fa);
        count      = (AW + 1)'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " valid"}, 32'(out_valid), 1);
    endtask

    // Expects out_ready high; consumes one word and checks its contents.
    task automatic collect(input string tag, input int ea, input int ed, input int el);
        wait_valid(tag);
        check({tag, " addr"}, 32'(out_addr), ea);
        check({tag, " data"}, 32'(out_data), ed);
        check({tag, " last"}, 32'(out_last), el);
        tick();
        check({tag, " drop"}, 32'(out_valid), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, " done"}, 32'(done), 1);
        tick();
        check({tag, " done off"}, 32'(done), 0);
        check({tag, " idle"}, 32'(busy), 0);
    endtask

    initial begin
        int h0;
        int r0;
        int bad;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;

        for (int i = 0; i < int'(NR); i++) mem[i] = DW'(8'hA0 + i);

        // Reset state
        repeat (2) tick();
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst rd_en", 32'(rd_en), 0);
        check("rst valid", 32'(out_valid), 0);
        check("rst last", 32'(out_last), 0);
        check("rst data", 32'(out_data), 0);
        check("rst addr", 32'(out_addr), 0);
        rst_n = 1'b1;
        tick();

        // Basic read with ready held high before valid
        out_ready = 1'b1;
        h0 = hs_cnt;
        start_op(2, 3);
        check("b rd_en", 32'(rd_en), 1);
        check("b rd_addr", 32'(rd_addr), 2);
        check("b busy", 32'(busy), 1);
        tick();
        check("b rd_en pulse", 32'(rd_en), 0);
        check("b early valid", 32'(out_valid), 0);
        check("b early hs", 32'(hs_cnt - h0), 0);
        tick();
        check("b valid lat", 32'(out_valid), 1);
        collect("b0", 2, 'hA2, 0);
        collect("b1", 3, 'hA3, 0);
        collect("b2", 4, 'hA4, 1);
        check("b done", 32'(done), 1);
        tick();
        check("b done off", 32'(done), 0);
        check("b idle", 32'(busy), 0);
        check("b hs count", 32'(hs_cnt - h0), 3);

        // Address wrap
        start_op(6, 4);
        collect("w0", 6, 'hA6, 0);
        collect("w1", 7, 'hA7, 0);
        collect("w2", 0, 'hA0, 0);
        collect("w3", 1, 'hA1, 1);
        wait_done("w");

        // Backpressure
        out_ready = 1'b0;
        start_op(0, 2);
        wait_valid("bp");
        r0  = rd_cnt;
        sa  = out_addr;
        sd  = out_data;
        bad = 0;
        repeat (5) begin
            tick();
            if (out_addr !== sa || out_data !== sd || out_valid !== 1'b1) bad++;
        end
        check("bp hold", 32'(bad), 0);
        check("bp addr", 32'(sa), 0);
        check("bp data", 32'(sd), 'hA0);
        check("bp no rd", 32'(rd_cnt - r0), 0);
        h0 = hs_cnt;
        out_ready = 1'b1;
        tick();
        check("bp one hs", 32'(hs_cnt - h0), 1);
        check("bp drop", 32'(out_valid), 0);
        collect("bp1", 1, 'hA1, 1);
        wait_done("bp");
        check("bp total hs", 32'(hs_cnt - h0), 2);

        // Full range via count 0, with a start pulse mid-sequence and in DONE
        h0 = hs_cnt;
        r0 = rd_cnt;
        start_op(0, 0);
        for (int i = 0; i < 4; i++) collect($sformatf("z%0d", i), i, 'hA0 + i, 0);
        start_op(5, 1);
        for (int i = 4; i < 8; i++)
            collect($sformatf("z%0d", i), i, 'hA0 + i, (i == 7) ? 1 : 0);
        check("z done", 32'(done), 1);
        first_addr = AW'(5);
        count      = (AW + 1)'(1);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("z done start", 32'(busy), 0);
        tick();
        check("z no rd", 32'(rd_en), 0);
        check("z still idle", 32'(busy), 0);
        check("z hs count", 32'(hs_cnt - h0), 8);
        check("z rd count", 32'(rd_cnt - r0), 8);

        // Full range via count NUM_REGS
        h0 = hs_cnt;
        start_op(5, 8);
        for (int i = 0; i < 8; i++)
            collect($sformatf("f%0d", i), (5 + i) % 8, 'hA0 + ((5 + i) % 8), (i == 7) ? 1 : 0);
        wait_done("f");
        check("f hs count", 32'(hs_cnt - h0), 8);

        // Mid-operation reset while in SEND
        out_ready = 1'b0;
        start_op(3, 2);
        wait_valid("mr");
        rst_n = 1'b0;
        #1;
        check("mr busy", 32'(busy), 0);
        check("mr valid", 32'(out_valid), 0);
        check("mr rd_en", 32'(rd_en), 0);
        check("mr done", 32'(done), 0);
        check("mr data", 32'(out_data), 0);
        check("mr addr", 32'(out_addr), 0);
        check("mr last", 32'(out_last), 0);
        #3;
        rst_n = 1'b1;
        r0 = rd_cnt;
        tick();
        tick();
        check("mr no rd", 32'(rd_cnt - r0), 0);
        check("mr no done", 32'(done), 0);
        out_ready = 1'b1;
        start_op(1, 1);
        collect("mr0", 1, 'hA1, 1);
        wait_done("mr");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
